// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter
// Description : Round-robin, burst-capped arbiter sharing one synchronous
//               single-port RAM between NUM_REQ cores.
// Revision    : 1.0
// ============================================================================
module ram_access_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int                IDX_W   = $clog2(NUM_REQ);
    localparam int                CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W:0]    NREQ    = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     owner, owner_nxt;
    logic [IDX_W-1:0]     prio_ptr, prio_nxt;
    logic [CNT_W-1:0]     burst_cnt, burst_nxt;

    logic [NUM_REQ-1:0]   owner_oh, skip_mask, cand;
    logic [IDX_W:0]       idx;
    logic [IDX_W-1:0]     win;
    logic                 win_any, keep, at_cap;

    logic [NUM_REQ-1:0]   rd_pend;
    logic [DATA_W-1:0]    rd_hold;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        at_cap          = (burst_cnt == CNT_MAX);
        keep            = (state == OWNED) && req[owner] && !at_cap;
        // A capped owner only steps aside when someone else is actually waiting
        skip_mask       = ((state == OWNED) && at_cap && |(req & ~owner_oh)) ? owner_oh : '0;
        cand            = req & ~skip_mask;
        idx             = '0;
        win             = owner;
        win_any         = keep;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, prio_ptr} + (IDX_W + 1)'(i);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_any && cand[idx[IDX_W-1:0]]) begin
                win_any = 1'b1;
                win     = idx[IDX_W-1:0];
            end
        end

        gnt = '0;
        if (win_any && !Reset) gnt[win] = 1'b1;

        state_nxt = state;
        owner_nxt = owner;
        prio_nxt  = prio_ptr;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nxt = OWNED;
                    owner_nxt = win;
                    burst_nxt = CNT_W'(1);
                end
            end
            OWNED: begin
                if (!win_any) begin
                    state_nxt = IDLE;
                    prio_nxt  = next_idx(owner);
                    burst_nxt = '0;
                end else if (win == owner) begin
                    if (!at_cap) burst_nxt = burst_cnt + 1'b1;
                end else begin
                    owner_nxt = win;
                    burst_nxt = CNT_W'(1);
                    prio_nxt  = next_idx(owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            owner       <= '0;
            prio_ptr    <= '0;
            burst_cnt   <= '0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            rd_pend     <= '0;
            rd_valid    <= '0;
            rd_hold     <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            prio_ptr  <= prio_nxt;
            burst_cnt <= burst_nxt;
            if (win_any) begin
                ram_we      <= req_we[win];
                ram_address <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                ram_wdata   <= req_wdata[int'(win)*DATA_W +: DATA_W];
            end else begin
                ram_we <= 1'b0;
            end
            // Read tag travels alongside the RAM's one-cycle latency
            rd_pend  <= (win_any && !req_we[win]) ? gnt : '0;
            rd_valid <= rd_pend;
            if (|rd_valid) rd_hold <= ram_rdata;
        end
    end

    assign rd_data = (|rd_valid) ? ram_rdata : rd_hold;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_arbiter
// Description : Random + directed bench for ram_access_arbiter (MAX_BURST 4 and 1).
// Revision    : 1.0
// ============================================================================
module tb_ram_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [N-1:0]      req, req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;

    logic [N-1:0]      gnt_o [2];
    logic [N-1:0]      rdv_o [2];
    logic [DW-1:0]     rdd_o [2];
    logic [AW-1:0]     ra_o  [2];
    logic              rwe_o [2];
    logic [DW-1:0]     rwd_o [2];
    logic [DW-1:0]     rrd   [2];

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    always #5 Clk = ~Clk;

    ram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt_o[0]), .rd_valid(rdv_o[0]), .rd_data(rdd_o[0]),
        .ram_address(ra_o[0]), .ram_we(rwe_o[0]), .ram_wdata(rwd_o[0]), .ram_rdata(rrd[0]));

    ram_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt_o[1]), .rd_valid(rdv_o[1]), .rd_data(rdd_o[1]),
        .ram_address(ra_o[1]), .ram_we(rwe_o[1]), .ram_wdata(rwd_o[1]), .ram_rdata(rrd[1]));

    // Synchronous RAM macros, read-before-write, one per DUT
    logic [DW-1:0] ram_mem [2][0:(1<<AW)-1];
    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            rrd[d] <= ram_mem[d][ra_o[d]];
            if (rwe_o[d]) ram_mem[d][ra_o[d]] = rwd_o[d];
        end
    end

    // Behavioural model: memory image updated in grant order plus arbitration state
    logic [DW-1:0] shadow [2][0:(1<<AW)-1];
    int            m_owner [2];
    int            m_cnt   [2];
    int            m_ptr   [2];
    logic          exp_we    [2];
    logic [AW-1:0] exp_addr  [2];
    logic [DW-1:0] exp_wdata [2];
    logic [N-1:0]  exp_rdv   [2];
    logic [DW-1:0] exp_rdd   [2];
    logic [N-1:0]  pend_v    [2];
    logic [DW-1:0] pend_d    [2];

    function automatic int maxb(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int pick(input int d);
        int o = m_owner[d];
        if (o >= 0 && req[o] && m_cnt[d] < maxb(d)) return o;
        for (int i = 0; i < N; i++) begin
            int c = (m_ptr[d] + i) % N;
            if (!req[c]) continue;
            if (c == o && m_cnt[d] == maxb(d) && (req & ~(4'(1) << c)) != 0) continue;
            return c;
        end
        return -1;
    endfunction

    task automatic model_reset(input int d);
        m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0;
        exp_we[d] = 1'b0; exp_addr[d] = '0; exp_wdata[d] = '0;
        exp_rdv[d] = '0; exp_rdd[d] = '0; pend_v[d] = '0; pend_d[d] = '0;
    endtask

    task automatic model_advance(input int d, input int w);
        logic [AW-1:0] a;
        exp_rdv[d] = pend_v[d];
        if (pend_v[d] != 0) exp_rdd[d] = pend_d[d];
        pend_v[d] = '0;
        if (w >= 0) begin
            a            = req_addr[w*AW +: AW];
            exp_we[d]    = req_we[w];
            exp_addr[d]  = a;
            exp_wdata[d] = req_wdata[w*DW +: DW];
            if (req_we[w]) shadow[d][a] = req_wdata[w*DW +: DW];
            else begin
                pend_v[d] = 4'(1) << w;
                pend_d[d] = shadow[d][a];
            end
        end else begin
            exp_we[d] = 1'b0;
        end
        if (w < 0) begin
            if (m_owner[d] >= 0) m_ptr[d] = (m_owner[d] + 1) % N;
            m_owner[d] = -1; m_cnt[d] = 0;
        end else if (m_owner[d] < 0) begin
            m_owner[d] = w; m_cnt[d] = 1;
        end else if (w == m_owner[d]) begin
            if (m_cnt[d] < maxb(d)) m_cnt[d]++;
        end else begin
            m_ptr[d] = (m_owner[d] + 1) % N;
            m_owner[d] = w; m_cnt[d] = 1;
        end
    endtask

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < (1 << AW); a++) begin
                ram_mem[d][a] = DW'(a * 37 + 5);
                shadow[d][a]  = DW'(a * 37 + 5);
            end
            model_reset(d);
        end
    end

    always @(posedge Clk) started <= 1'b1;

    always @(negedge Clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                automatic int w = pick(d);
                automatic logic [N-1:0] eg = (w < 0 || Reset) ? '0 : (4'(1) << w);
                chk("gnt",         d, 32'(gnt_o[d]), 32'(eg));
                chk("ram_we",      d, 32'(rwe_o[d]), 32'(exp_we[d]));
                chk("ram_address", d, 32'(ra_o[d]),  32'(exp_addr[d]));
                chk("ram_wdata",   d, 32'(rwd_o[d]), 32'(exp_wdata[d]));
                chk("rd_valid",    d, 32'(rdv_o[d]), 32'(exp_rdv[d]));
                chk("rd_data",     d, 32'(rdd_o[d]), 32'(exp_rdd[d]));
                if (Reset) model_reset(d);
                else       model_advance(d, w);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_core(input int i, input bit r, input bit we, input int a, input int dt);
        req[i]              = r;
        req_we[i]           = we;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = DW'(dt);
    endtask

    logic [N-1:0] last_g;
    int           density;

    initial begin
        Reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) step();
        @(negedge Clk);
        chk("lit_reset_gnt",  0, 32'(gnt_o[0]), 32'h0);
        chk("lit_reset_we",   0, 32'(rwe_o[0]), 32'h0);
        chk("lit_reset_rdv",  0, 32'(rdv_o[0]), 32'h0);
        chk("lit_reset_addr", 0, 32'(ra_o[0]),  32'h0);

        // Core 2 writes then reads back 0x0010
        step(); Reset = 1'b0; set_core(2, 1, 1, 'h10, 'hBEEF);
        @(negedge Clk); chk("lit_c2_gnt", 0, 32'(gnt_o[0]), 32'b0100);
        step(); set_core(2, 1, 0, 'h10, 0);
        @(negedge Clk);
        chk("lit_c2_we",    0, 32'(rwe_o[0]), 32'h1);
        chk("lit_c2_addr",  0, 32'(ra_o[0]),  32'h10);
        chk("lit_c2_wdata", 0, 32'(rwd_o[0]), 32'hBEEF);
        step(); req = '0;
        step();
        @(negedge Clk);
        chk("lit_c2_rdv",  0, 32'(rdv_o[0]), 32'b0100);
        chk("lit_c2_rdd",  0, 32'(rdd_o[0]), 32'hBEEF);

        // Core 1 writes addr 5, core 2 reads it the next cycle
        step(); set_core(1, 1, 1, 5, 'h1234);
        step(); req = '0; set_core(2, 1, 0, 5, 0);
        step(); req = '0;
        step();
        @(negedge Clk);
        chk("lit_x_rdv", 0, 32'(rdv_o[0]), 32'b0100);
        chk("lit_x_rdd", 0, 32'(rdd_o[0]), 32'h1234);

        // All four cores requesting continuously
        step(); Reset = 1'b1; req = '0;
        step();
        step(); Reset = 1'b0;
        for (int i = 0; i < N; i++) set_core(i, 1, 1, $urandom_range(0, 31), $urandom);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            chk("lit_rr_mb4", 0, 32'(gnt_o[0]), 32'(1) << ((k / 4) % 4));
            chk("lit_rr_mb1", 1, 32'(gnt_o[1]), 32'(1) << (k % 4));
            step();
            for (int i = 0; i < N; i++) set_core(i, 1, 1, $urandom_range(0, 31), $urandom);
        end

        // Core 3 owns, core 0 joins, owner releases: pointer wraps to core 0
        Reset = 1'b1; req = '0;
        step();
        step(); Reset = 1'b0; set_core(3, 1, 0, 7, 0);
        step();
        step(); set_core(0, 1, 0, 8, 0);
        @(negedge Clk); chk("lit_own_keep", 0, 32'(gnt_o[0]), 32'b1000);
        step(); req[3] = 1'b0;
        @(negedge Clk); chk("lit_own_wrap", 0, 32'(gnt_o[0]), 32'b0001);

        // Read in flight when Reset arrives
        step(); req = '0;
        step(); set_core(0, 1, 0, 'h10, 0);
        @(negedge Clk); chk("lit_rst_rdgnt", 0, 32'(gnt_o[0]), 32'b0001);
        step(); req = '0; Reset = 1'b1;
        step(); Reset = 1'b0;
        @(negedge Clk);
        chk("lit_rst_rdv0", 0, 32'(rdv_o[0]), 32'h0);
        chk("lit_rst_we",   0, 32'(rwe_o[0]), 32'h0);
        step();
        @(negedge Clk); chk("lit_rst_rdv1", 0, 32'(rdv_o[0]), 32'h0);
        step(); set_core(1, 1, 1, 3, 'h55AA);
        @(negedge Clk);
        chk("lit_rst_rdv2", 0, 32'(rdv_o[0]), 32'h0);
        chk("lit_rst_gnt",  0, 32'(gnt_o[0]), 32'b0010);
        last_g = gnt_o[0];

        // Randomized traffic with occasional resets
        density = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) density = $urandom_range(20, 100);
            step();
            Reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_g[i])
                    set_core(i, ($urandom_range(0, 99) < density), $urandom_range(0, 1),
                             $urandom_range(0, 31), $urandom);
            end
            @(negedge Clk);
            last_g = gnt_o[0];
        end

        step(); req = '0;
        repeat (4) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
